// File: rtl/matrix_output_buffer.sv
// Collects the engine's output rows, then streams the full matrix
// row-major, one element per valid/ready transfer.
module matrix_output_buffer #(
  parameter int BATCH_SIZE          = 8,
  parameter int LOG_BATCH_SIZE      = 3,
  parameter int OUTPUT_FEATURES     = 8,
  parameter int LOG_OUTPUT_FEATURES = 3,
  parameter int OUTPUT_WIDTH        = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData,
  input  logic [LOG_BATCH_SIZE-1:0]               outputAddr,
  input  logic                                    outputWrEn,
  input  logic                                    outReady,
  output logic                                    outValid,
  output logic [OUTPUT_WIDTH-1:0]                 outData,
  output logic [LOG_BATCH_SIZE-1:0]               outRow,
  output logic [LOG_OUTPUT_FEATURES-1:0]          outCol,
  output logic                                    outLast,
  output logic                                    done,
  output logic                                    writeErr
);

  localparam logic FILL  = 1'b0;
  localparam logic DRAIN = 1'b1;

  localparam logic [LOG_BATCH_SIZE-1:0] LAST_ROW =
    LOG_BATCH_SIZE'(BATCH_SIZE - 1);
  localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_COL =
    LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);

  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] mem [BATCH_SIZE];

  logic                           state;
  logic [BATCH_SIZE-1:0]          rowValid;
  logic [BATCH_SIZE-1:0]          nextValid;
  logic [LOG_BATCH_SIZE-1:0]      row;
  logic [LOG_OUTPUT_FEATURES-1:0] col;
  logic                           addrOk;
  logic                           draining;
  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] rowWord;

  // Address range check only exists when M is not a power of two.
  generate
    if ((1 << LOG_BATCH_SIZE) == BATCH_SIZE) begin : gFullRange
      assign addrOk = 1'b1;
    end else begin : gPartRange
      assign addrOk = 32'(outputAddr) < BATCH_SIZE;
    end
  endgenerate

  assign draining  = state == DRAIN;
  assign nextValid = rowValid | (BATCH_SIZE'(1) << outputAddr);
  assign rowWord   = mem[row];

  always_ff @(posedge clk) begin
    if (!draining && outputWrEn && addrOk)
      mem[outputAddr] <= outputData;
  end

  always_comb begin
    outValid = draining;
    outData  = '0;
    outRow   = '0;
    outCol   = '0;
    outLast  = 1'b0;
    if (draining) begin
      outData = rowWord[col*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      outRow  = row;
      outCol  = col;
      outLast = (row == LAST_ROW) && (col == LAST_COL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      rowValid <= '0;
      row      <= '0;
      col      <= '0;
      done     <= 1'b0;
      writeErr <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FILL: begin
          if (outputWrEn) begin
            if (addrOk) begin
              rowValid <= nextValid;
              if (&nextValid) begin
                state <= DRAIN;
                row   <= '0;
                col   <= '0;
              end
            end else begin
              writeErr <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Storage is frozen while draining; late writes are flagged.
          if (outputWrEn)
            writeErr <= 1'b1;
          if (outReady) begin
            if (outLast) begin
              state    <= FILL;
              rowValid <= '0;
              row      <= '0;
              col      <= '0;
              done     <= 1'b1;
            end else if (col == LAST_COL) begin
              col <= '0;
              row <= row + LOG_BATCH_SIZE'(1);
            end else begin
              col <= col + LOG_OUTPUT_FEATURES'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_output_buffer.sv
// Bench for matrix_output_buffer: matrix-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_matrix_output_buffer;

  localparam int M = 8;
  localparam int O = 8;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [O*W-1:0] outputData = '0;
  logic [2:0]   outputAddr = '0;
  logic         outputWrEn = 1'b0;
  logic         outReady = 1'b0;
  logic         outValid;
  logic [W-1:0] outData;
  logic [2:0]   outRow;
  logic [2:0]   outCol;
  logic         outLast;
  logic         done;
  logic         writeErr;

  matrix_output_buffer dut (
    .clk(clk), .rst(rst),
    .outputData(outputData), .outputAddr(outputAddr),
    .outputWrEn(outputWrEn), .outReady(outReady),
    .outValid(outValid), .outData(outData),
    .outRow(outRow), .outCol(outCol), .outLast(outLast),
    .done(done), .writeErr(writeErr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic [W-1:0] cap[$];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e)
      $display("FAIL %s got %h want %h at %0t", nm, a, e, $time);
    else
      passed++;
  endtask

  function automatic logic [W-1:0] capAt(input int i);
    if (i < cap.size()) return cap[i];
    return 'x;
  endfunction

  // Matrix-level model: a set of captured rows and a stream index.
  logic [W-1:0] mStore [M][O];
  logic [M-1:0] mValid;
  bit mDrain, mDone, mErr;
  int mIdx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mValid = '0; mDrain = 0; mIdx = 0; mDone = 0; mErr = 0;
    end else begin
      mDone = 0;
      if (!mDrain) begin
        if (outputWrEn) begin
          for (int c = 0; c < O; c++)
            mStore[outputAddr][c] = outputData[c*W +: W];
          mValid[outputAddr] = 1'b1;
          if (&mValid) begin
            mDrain = 1; mIdx = 0;
          end
        end
      end else begin
        if (outputWrEn) mErr = 1;
        if (outReady) begin
          if (mIdx == M*O-1) begin
            mDrain = 0; mValid = '0; mDone = 1;
          end else begin
            mIdx++;
          end
        end
      end
    end
  end

  logic [W-1:0] eData;
  int eRow, eCol;
  bit eLast;

  always @(negedge clk) begin
    if (!rst) begin
      eData = mDrain ? mStore[mIdx/O][mIdx%O] : '0;
      eRow  = mDrain ? mIdx / O : 0;
      eCol  = mDrain ? mIdx % O : 0;
      eLast = mDrain && (mIdx == M*O-1);
      chk("outValid", 32'(outValid), 32'(mDrain));
      chk("outData", 32'(outData), 32'(eData));
      chk("outRow", 32'(outRow), 32'(eRow));
      chk("outCol", 32'(outCol), 32'(eCol));
      chk("outLast", 32'(outLast), 32'(eLast));
      chk("done", 32'(done), 32'(mDone));
      chk("writeErr", 32'(writeErr), 32'(mErr));
      if (outValid && outReady) cap.push_back(outData);
    end
  end

  function automatic logic [O*W-1:0] mkRow(input int r,
                                           input logic [W-1:0] base);
    logic [O*W-1:0] v;
    for (int c = 0; c < O; c++)
      v[c*W +: W] = base + W'(r*16 + c);
    return v;
  endfunction

  task automatic wr(input int a, input logic [O*W-1:0] d);
    outputWrEn = 1'b1;
    outputAddr = 3'(a);
    outputData = d;
    @(posedge clk); #1;
    outputWrEn = 1'b0;
  endtask

  task automatic fill(input logic [W-1:0] base);
    for (int r = 0; r < M; r++) wr(r, mkRow(r, base));
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    // Reset state
    #1;
    chk("rstValid", 32'(outValid), 0);
    chk("rstDone", 32'(done), 0);
    chk("rstErr", 32'(writeErr), 0);
    chk("rstData", 32'(outData), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic fill and drain
    outReady = 1'b1;
    for (int r = 0; r < M-1; r++) wr(r, mkRow(r, 16'h0000));
    chk("fillNotValid", 32'(outValid), 0);
    wr(M-1, mkRow(M-1, 16'h0000));
    chk("validAfterRow7", 32'(outValid), 1);
    waitDone(n);
    chk("basicCycles", 32'(n), 64);
    chk("basicCount", 32'(cap.size()), 64);
    chk("basicFirst", 32'(capAt(0)), 32'h0000);
    chk("basicElem9", 32'(capAt(9)), 32'h0011);
    chk("basicLast", 32'(capAt(63)), 32'h0077);
    chk("basicErr", 32'(writeErr), 0);

    // Backpressure, outReady alternating starting at 0
    @(posedge clk); #1;
    cap.delete();
    outReady = 1'b0;
    fill(16'h0000);
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
      outReady = n[0];
    end
    outReady = 1'b1;
    chk("bpCycles", 32'(n), 128);
    chk("bpCount", 32'(cap.size()), 64);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (capAt(i) !== W'((i/8)*16 + i%8)) bad++;
    chk("bpSequence", 32'(bad), 0);

    // Out-of-order fill with an overwrite of row 3
    @(posedge clk); #1;
    cap.delete();
    for (int r = M-1; r >= 1; r--) wr(r, mkRow(r, 16'h0000));
    chk("oooNotValidA", 32'(outValid), 0);
    wr(3, {O{16'hAAAA}});
    chk("oooNotValidB", 32'(outValid), 0);
    wr(0, mkRow(0, 16'h0000));
    chk("oooValid", 32'(outValid), 1);
    waitDone(n);
    chk("oooRow3First", 32'(capAt(24)), 32'hAAAA);
    chk("oooRow3Last", 32'(capAt(31)), 32'hAAAA);
    chk("oooRow2Last", 32'(capAt(23)), 32'h0027);
    chk("oooRow4First", 32'(capAt(32)), 32'h0040);

    // Write during drain
    @(posedge clk); #1;
    cap.delete();
    fill(16'h0000);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("wdRowAt10", 32'(outRow), 1);
    chk("wdColAt10", 32'(outCol), 2);
    wr(2, {O{16'hFFFF}});
    chk("wdErrSet", 32'(writeErr), 1);
    waitDone(n);
    chk("wdRow2First", 32'(capAt(16)), 32'h0020);
    chk("wdRow2Mid", 32'(capAt(21)), 32'h0025);
    chk("wdErrSticky", 32'(writeErr), 1);

    // Reset mid-drain
    @(posedge clk); #1;
    cap.delete();
    fill(16'h0500);
    repeat (20) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rstMidValid", 32'(outValid), 0);
    chk("rstMidErr", 32'(writeErr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cap.delete();
    fill(16'h1000);
    waitDone(n);
    chk("postRstCycles", 32'(n), 64);
    chk("postRstCount", 32'(cap.size()), 64);
    chk("postRstFirst", 32'(capAt(0)), 32'h1000);
    chk("postRstLast", 32'(capAt(63)), 32'h1077);

    // Back-to-back: second fill starts in the done cycle
    chk("b2bDoneCycle", 32'(done), 1);
    cap.delete();
    fill(16'h2000);
    chk("b2bValid", 32'(outValid), 1);
    waitDone(n);
    chk("b2bCycles", 32'(n), 64);
    chk("b2bCount", 32'(cap.size()), 64);
    bad = 0;
    for (int i = 0; i < cap.size(); i++)
      if (cap[i][15:8] !== 8'h20) bad++;
    chk("b2bNoStale", 32'(bad), 0);
    chk("b2bFirst", 32'(capAt(0)), 32'h2000);
    chk("b2bLast", 32'(capAt(63)), 32'h2077);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
